rtc_hora_writer: RTL
====================

RTC_HORA_WRITER -- requirements
Module: rtc_hora_writer

Interface
REQ-001 Parameter T_STB, default 4: strobe-low width in clk cycles, legal range 1..15.
REQ-002 Parameter T_GAP, default 2: idle cycles between bus transactions, legal range 1..15.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 HC / MC / SC  in  8 each  edited BCD hours, minutes and seconds from the time-edit stage.
REQ-006 AmPm  in  1  1 = PM; meaningful only when format = 1.
REQ-007 format  in  1  1 = 12-hour mode, 0 = 24-hour mode.
REQ-008 wr_start  in  1  commit request; acted on at its rising edge only.
REQ-009 AD_out  out  8  RTC multiplexed address/data bus, output value.
REQ-010 ad_oe  out  1  1 = drive AD_out onto the shared bus.
REQ-011 CS_n / WR_n / RD_n  out  1 each  RTC chip select, write strobe and read strobe; all active-low.
REQ-012 AD_sel  out  1  0 = address phase, 1 = data phase.
REQ-013 busy  out  1  high from the capture cycle through the final hold/gap cycle.
REQ-014 done  out  1  one-cycle pulse when the sequence completes.
REQ-015 err  out  1  one-cycle pulse when the captured time is rejected.

Function
REQ-016 A rising edge on wr_start while idle SHALL snapshot HC, MC, SC, AmPm and format in one capture cycle; input changes after that cycle SHALL be ignored.
REQ-017 The capture cycle SHALL validate the snapshot:
- every nibble of MC and SC <= 9, with MC and SC <= 0x59;
- 24-hour mode: HC <= 0x23;
- 12-hour mode: HC in 0x01..0x12.
REQ-018 On validation failure the block SHALL pulse err on the next cycle, return to IDLE, and produce no bus activity.
REQ-019 On success the block SHALL run four transactions in this fixed order:
- addr 0x21 = SC;
- addr 0x22 = MC;
- addr 0x23 = hour byte;
- addr 0xF1 = 0x00 (transfer command).
REQ-020 The hour byte SHALL be {1'b1, 1'b0, AmPm, HC[4:0]} in 12-hour mode and {2'b00, HC[5:0]} in 24-hour mode.
REQ-021 Each transaction SHALL consist of an address phase (AD_sel = 0) followed by a data phase (AD_sel = 1).
REQ-022 Each phase SHALL last: 1 setup cycle (CS_n = 0, WR_n = 1), then T_STB cycles with WR_n = 0, then 1 hold cycle (WR_n = 1).
REQ-023 CS_n = 0 and ad_oe = 1 SHALL hold for both phases of a transaction; T_GAP idle cycles with CS_n = 1 and ad_oe = 0 SHALL follow each transaction.
REQ-024 AD_out SHALL be stable from the setup cycle through the hold cycle of each phase; RD_n SHALL stay 1 at all times.
REQ-025 FSM states: IDLE, CAPTURE, SETUP, STROBE, HOLD, GAP, FINISH.
- the phase flag (address/data) and the transaction index 0..3 are separate registers;
- HOLD of the data phase goes to GAP; GAP after index 3 goes to FINISH.
REQ-026 FINISH SHALL pulse done for one cycle, then return to IDLE.
REQ-027 Total latency from the wr_start edge to done = 1 + 4*(2*(T_STB+2)+T_GAP) + 1 cycles; this is 58 cycles at the defaults.
REQ-028 A wr_start edge while busy SHALL be ignored, not queued.
REQ-029 A wr_start held high SHALL start exactly one sequence; a new sequence requires wr_start to go low and then high again.

Reset
REQ-030 Reset SHALL set the state to IDLE with these outputs from the next edge: CS_n = WR_n = RD_n = 1, ad_oe = 0, AD_sel = 0, AD_out = 0x00, busy = done = err = 0.
REQ-031 The edge-detect register SHALL reset to 1, so a wr_start held high through reset does not start a sequence.
REQ-032 Reset asserted mid-transaction SHALL release the bus on the next edge and discard the snapshot; no partial completion or done pulse follows.

Structure
REQ-033 A shared package SHALL hold:
- RTC address constants 0x21, 0x22, 0x23, 0xF1;
- the FSM state enum;
- the default values of T_STB and T_GAP.
REQ-034 The setup/strobe/hold timing of a single phase SHALL be factored into one sub-module, rtc_bus_phase (start in; addr/data byte in; strobe, hold and phase-done out).

Verification
REQ-035 24h write: HC = 0x17, MC = 0x45, SC = 0x09, format = 0, wr_start pulse -> bytes 0x21/0x09, 0x22/0x45, 0x23/0x17, 0xF1/0x00 in order; done at cycle 58.
REQ-036 12h PM: HC = 0x11, AmPm = 1, format = 1 -> hour data byte 0xB1.
REQ-037 Invalid input: MC = 0x60 -> err pulse, CS_n stays 1, no done pulse.
REQ-038 Busy and held start: second wr_start pulse during transaction 2 -> ignored, exactly 4 transactions; wr_start held high 200 cycles -> exactly one sequence.
REQ-039 Reset during STROBE of transaction 1 -> next edge CS_n = WR_n = 1 and ad_oe = 0; no done pulse.
REQ-040 Timing check: T_STB = 1, T_GAP = 1 -> every WR_n low pulse is 1 cycle and done arrives at cycle 30.

Source files
------------

// File: rtl/rtc_hora_writer_pkg.sv
// Shared constants, FSM state type and time-validation helpers for the RTC hour writer.
package rtc_hora_writer_pkg;

  localparam int unsigned T_STB_DEF = 4;
  localparam int unsigned T_GAP_DEF = 2;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned GAP_W     = 4;
  localparam int unsigned IDX_W     = 2;

  localparam logic [7:0] ADDR_SEC  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HOUR = 8'h23;
  localparam logic [7:0] ADDR_XFER = 8'hF1;
  localparam logic [7:0] XFER_CMD  = 8'h00;

  typedef enum logic [2:0] {
    IDLE, CAPTURE, SETUP, STROBE, HOLD, GAP, FINISH
  } state_e;

  typedef struct packed {
    logic [7:0] hc;
    logic [7:0] mc;
    logic [7:0] sc;
    logic       ampm;
    logic       fmt;
  } snap_t;

  // Minutes/seconds: low nibble is a decimal digit and value at most 59.
  function automatic logic ms_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v <= 8'h59);
  endfunction

  function automatic logic time_ok(input snap_t s);
    logic hr_ok;
    if (s.fmt) hr_ok = (s.hc >= 8'h01) && (s.hc <= 8'h12);
    else       hr_ok = (s.hc <= 8'h23);
    return ms_ok(s.mc) && ms_ok(s.sc) && hr_ok;
  endfunction

  // 12-hour mode sets bit7 and carries the PM flag in bit5.
  function automatic logic [7:0] hour_byte(input snap_t s);
    if (s.fmt) return {1'b1, 1'b0, s.ampm, s.hc[4:0]};
    else       return {2'b00, s.hc[5:0]};
  endfunction

endpackage

// File: rtl/rtc_hora_writer_bus_phase.sv
// One bus phase: a setup cycle, T_STB cycles of WR_n low, then a hold cycle.
module rtc_bus_phase
  import rtc_hora_writer_pkg::*;
#(
  parameter int unsigned T_STB = T_STB_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic [7:0] data_o,
  output logic       wr_n_o,
  output logic       hold_o,
  output logic       strobe_last_c
);

  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(T_STB);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(T_STB + 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             wr_n_q, wr_n_d;
  logic             hold_q, hold_d;

  // Count 0 is setup, 1..T_STB strobe, T_STB+1 hold; a new start wins over hold.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
      data_d   = byte_i;
    end else if (active_q) begin
      if (cnt_q == HOLD_CNT) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    wr_n_d        = ~(active_d && (cnt_d != '0) && (cnt_d <= STB_LAST));
    hold_d        = active_d && (cnt_d == HOLD_CNT);
    strobe_last_c = active_q && (cnt_q == STB_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      data_q   <= 8'h00;
      wr_n_q   <= 1'b1;
      hold_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      wr_n_q   <= wr_n_d;
      hold_q   <= hold_d;
    end
  end

  assign data_o = data_q;
  assign wr_n_o = wr_n_q;
  assign hold_o = hold_q;

endmodule

// File: rtl/rtc_hora_writer.sv
// Commits an edited time (sec, min, hour, transfer command) to the RTC over its muxed bus.
module rtc_hora_writer
  import rtc_hora_writer_pkg::*;
#(
  parameter int unsigned T_STB = T_STB_DEF,
  parameter int unsigned T_GAP = T_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] HC,
  input  logic [7:0] MC,
  input  logic [7:0] SC,
  input  logic       AmPm,
  input  logic       format,
  input  logic       wr_start,
  output logic [7:0] AD_out,
  output logic       ad_oe,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       AD_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(T_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(3);

  state_e           state_q, state_d;
  snap_t            snap_q, snap_d;
  logic             phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             wr_prev_q, wr_prev_d;
  logic             cs_n_q, cs_n_d;
  logic             ad_oe_q, ad_oe_d;
  logic             ad_sel_q, ad_sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             wr_rise_c, snap_ok_c, bus_c, phase_start_c, strobe_last_c, hold_w;
  logic [7:0]       addr_c, data_c, phase_byte_c;

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    wr_prev_d = wr_start;
    wr_rise_c = wr_start & ~wr_prev_q;
    snap_ok_c = time_ok(snap_q);

    unique case (state_q)
      IDLE: begin
        if (wr_rise_c) begin
          state_d = CAPTURE;
          snap_d  = '{hc: HC, mc: MC, sc: SC, ampm: AmPm, fmt: format};
        end
      end
      CAPTURE: begin
        if (snap_ok_c) begin
          state_d = SETUP;
          phase_d = 1'b0;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: if (strobe_last_c) state_d = HOLD;
      HOLD: begin
        if (hold_w) begin
          if (!phase_q) begin
            state_d = SETUP;
            phase_d = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = FINISH;
          end else begin
            state_d = SETUP;
            idx_d   = idx_q + IDX_W'(1);
            phase_d = 1'b0;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs decode the next state so the registered pins line up with the state.
    bus_c         = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cs_n_d        = ~bus_c;
    ad_oe_d       = bus_c;
    ad_sel_d      = bus_c & phase_d;
    busy_d        = bus_c || (state_d == CAPTURE) || (state_d == GAP);
    done_d        = (state_d == FINISH);
    err_d         = (state_q == CAPTURE) && !snap_ok_c;
    phase_start_c = (state_d == SETUP);

    unique case (idx_d)
      2'd0: begin addr_c = ADDR_SEC;  data_c = snap_q.sc;         end
      2'd1: begin addr_c = ADDR_MIN;  data_c = snap_q.mc;         end
      2'd2: begin addr_c = ADDR_HOUR; data_c = hour_byte(snap_q); end
      default: begin addr_c = ADDR_XFER; data_c = XFER_CMD; end
    endcase
    phase_byte_c = phase_d ? data_c : addr_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      phase_q   <= 1'b0;
      idx_q     <= '0;
      gap_q     <= '0;
      wr_prev_q <= 1'b1;
      cs_n_q    <= 1'b1;
      ad_oe_q   <= 1'b0;
      ad_sel_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      wr_prev_q <= wr_prev_d;
      cs_n_q    <= cs_n_d;
      ad_oe_q   <= ad_oe_d;
      ad_sel_q  <= ad_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  rtc_bus_phase #(.T_STB(T_STB)) u_phase (
    .clk           (clk),
    .reset         (reset),
    .start_i       (phase_start_c),
    .byte_i        (phase_byte_c),
    .data_o        (AD_out),
    .wr_n_o        (WR_n),
    .hold_o        (hold_w),
    .strobe_last_c (strobe_last_c)
  );

  assign CS_n   = cs_n_q;
  assign ad_oe  = ad_oe_q;
  assign AD_sel = ad_sel_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign RD_n   = 1'b1;

endmodule
